// File: rtl/iter_multiplier.sv
// -----------------------------------------------------------------------------
// iter_multiplier
//   Multi-cycle 32x32 radix-2 shift-add multiplier for the MIPS32 execute
//   stage. Handles MULT/MULTU and, with acc_en, MADD/MADDU/MSUB/MSUBU by
//   combining the product with the current {HI,LO} value.
//
// Handshake (shared with the iterative divider):
//   The requester raises start and holds it high until it sees ready. While
//   start stays high in the final state, ready and res are held. The first
//   clock edge that sees start low clears both, so ready falls one cycle after
//   start falls. Dropping start before ready rises cancels the result. abandon
//   is a synchronous flush that clears everything at the next edge.
//
// Ports:
//   clk      in   1   system clock, rising edge
//   rst      in   1   asynchronous reset, active-high
//   start    in   1   request, held until ready
//   abandon  in   1   synchronous cancel (flush/exception)
//   signmul  in   1   1 = signed operands
//   acc_en   in   1   1 = combine product with hilo_in
//   acc_sub  in   1   with acc_en: 1 = hilo_in - product, 0 = hilo_in + product
//   opr1     in  32   multiplicand
//   opr2     in  32   multiplier
//   hilo_in  in  64   {HI,LO} accumulate source, sampled in the fixup state
//   ready    out  1   result valid
//   res      out 64   {HI,LO} result
//   state    out  2   current FSM state (debug visibility)
// -----------------------------------------------------------------------------
module iter_multiplier (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abandon,
    input  logic        signmul,
    input  logic        acc_en,
    input  logic        acc_sub,
    input  logic [31:0] opr1,
    input  logic [31:0] opr2,
    input  logic [63:0] hilo_in,
    output logic        ready,
    output logic [63:0] res,
    output logic [1:0]  state
);

    localparam logic [1:0] MUL_FREE = 2'd0;
    localparam logic [1:0] MUL_ON   = 2'd1;
    localparam logic [1:0] MUL_FIX  = 2'd2;
    localparam logic [1:0] MUL_END  = 2'd3;

    logic [63:0] mcand;
    logic [31:0] mplier;
    logic [63:0] prod;
    logic [5:0]  cnt;
    logic        neg;
    logic        acc_en_q;
    logic        acc_sub_q;

    logic [31:0] abs1;
    logic [31:0] abs2;
    logic [63:0] prod_signed;
    logic [63:0] fix_val;

    // Magnitudes of the operands. 0x80000000 negates to itself and is then
    // treated as the unsigned value 2^31, which gives the right magnitude.
    always_comb begin
        abs1 = (signmul && opr1[31]) ? (~opr1 + 32'd1) : opr1;
        abs2 = (signmul && opr2[31]) ? (~opr2 + 32'd1) : opr2;
    end

    // Fixup: restore the sign, then optionally accumulate against HI/LO.
    always_comb begin
        prod_signed = neg ? (~prod + 64'd1) : prod;
        if (acc_en_q) begin
            fix_val = acc_sub_q ? (hilo_in - prod_signed) : (hilo_in + prod_signed);
        end else begin
            fix_val = prod_signed;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= MUL_FREE;
            ready     <= 1'b0;
            res       <= 64'd0;
            cnt       <= 6'd0;
            mcand     <= 64'd0;
            mplier    <= 32'd0;
            prod      <= 64'd0;
            neg       <= 1'b0;
            acc_en_q  <= 1'b0;
            acc_sub_q <= 1'b0;
        end else if (abandon) begin
            state     <= MUL_FREE;
            ready     <= 1'b0;
            res       <= 64'd0;
            cnt       <= 6'd0;
            mcand     <= 64'd0;
            mplier    <= 32'd0;
            prod      <= 64'd0;
            neg       <= 1'b0;
            acc_en_q  <= 1'b0;
            acc_sub_q <= 1'b0;
        end else begin
            case (state)
                MUL_FREE: begin
                    if (start) begin
                        mcand     <= {32'd0, abs1};
                        mplier    <= abs2;
                        neg       <= signmul & (opr1[31] ^ opr2[31]);
                        acc_en_q  <= acc_en;
                        acc_sub_q <= acc_sub;
                        prod      <= 64'd0;
                        cnt       <= 6'd0;
                        // A zero operand needs no iteration; the fixup still
                        // runs so accumulate forms pass hilo_in through.
                        if (opr1 == 32'd0 || opr2 == 32'd0) begin
                            state <= MUL_FIX;
                        end else begin
                            state <= MUL_ON;
                        end
                    end else begin
                        ready <= 1'b0;
                        res   <= 64'd0;
                    end
                end

                MUL_ON: begin
                    if (cnt != 6'd32) begin
                        if (mplier[0]) begin
                            prod <= prod + mcand;
                        end
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        // Leave on the 32nd iteration edge itself so the
                        // fixup follows immediately (fixup on E33, ready
                        // after E34).
                        if (cnt == 6'd31) begin
                            cnt   <= 6'd0;
                            state <= MUL_FIX;
                        end else begin
                            cnt <= cnt + 6'd1;
                        end
                    end else begin
                        cnt   <= 6'd0;
                        state <= MUL_FIX;
                    end
                end

                MUL_FIX: begin
                    prod  <= fix_val;
                    state <= MUL_END;
                end

                MUL_END: begin
                    if (start) begin
                        res   <= prod;
                        ready <= 1'b1;
                    end else begin
                        state <= MUL_FREE;
                        ready <= 1'b0;
                        res   <= 64'd0;
                    end
                end

                default: begin
                    state <= MUL_FREE;
                    ready <= 1'b0;
                    res   <= 64'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iter_multiplier.sv
module tb_iter_multiplier;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abandon;
    logic        signmul;
    logic        acc_en;
    logic        acc_sub;
    logic [31:0] opr1;
    logic [31:0] opr2;
    logic [63:0] hilo_in;
    logic        ready;
    logic [63:0] res;
    logic [1:0]  state;

    always #5 clk = ~clk;

    iter_multiplier dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .abandon (abandon),
        .signmul (signmul),
        .acc_en  (acc_en),
        .acc_sub (acc_sub),
        .opr1    (opr1),
        .opr2    (opr2),
        .hilo_in (hilo_in),
        .ready   (ready),
        .res     (res),
        .state   (state)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- scoreboard ----------------
    logic [63:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on the operand values.
    function automatic logic [63:0] model(input logic s, input logic ae, input logic asb,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input logic [63:0] h);
        logic [63:0] p;
        longint sa;
        longint sb;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            p  = 64'(sa * sb);
        end else begin
            p = {32'd0, a} * {32'd0, b};
        end
        if (ae) return asb ? (h - p) : (h + p);
        return p;
    endfunction

    // ---------------- driver ----------------
    // Called at a negedge. Applies an operation, waits for ready, checks the
    // ready latency and result, holds start for two more cycles, then drops it.
    task automatic run_op(input string name, input logic s, input logic [31:0] a,
                          input logic [31:0] b, input logic ae, input logic asb,
                          input logic [63:0] h);
        int n;
        int lat;
        logic [63:0] exp;
        signmul = s; opr1 = a; opr2 = b; acc_en = ae; acc_sub = asb; hilo_in = h;
        start   = 1'b1;
        exp_q.push_back(model(s, ae, asb, a, b, h));
        lat = (a == 32'd0 || b == 32'd0) ? 2 : 34;
        @(posedge clk);                 // E0: start sampled
        @(negedge clk);
        n = 0;
        while (!ready && n < 60) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        exp = exp_q.pop_front();
        chk({name, " latency"}, 64'(n), 64'(lat));
        chk({name, " res"}, res, exp);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            chk({name, " ready held"}, 64'(ready), 64'd1);
            chk({name, " res held"}, res, exp);
        end
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk({name, " ready cleared"}, 64'(ready), 64'd0);
        chk({name, " res cleared"}, res, 64'd0);
        chk({name, " state free"}, 64'(state), 64'd0);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        string       name;
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic        ae;
        logic        asb;
        logic [63:0] h;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{"umax",   1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 64'd0,    64'hFFFF_FFFE_0000_0001};
        vecs[1] = '{"sneg",   1'b1, 32'hFFFF_FFFD, 32'd7,         1'b0, 1'b0, 64'd0,    64'hFFFF_FFFF_FFFF_FFEB};
        vecs[2] = '{"smin",   1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 64'd0,    64'h4000_0000_0000_0000};
        vecs[3] = '{"madd",   1'b1, 32'd2,         32'd3,         1'b1, 1'b0, 64'h10,   64'h0000_0000_0000_0016};
        vecs[4] = '{"msub",   1'b1, 32'd1,         32'd1,         1'b1, 1'b1, 64'd0,    64'hFFFF_FFFF_FFFF_FFFF};
        vecs[5] = '{"zero",   1'b0, 32'h1234,      32'd0,         1'b1, 1'b0, 64'h5,    64'h5};
    end

    // ---------------- test sequence ----------------
    initial begin
        int n;
        logic [31:0] ra;
        logic [31:0] rb;
        rst = 1'b1; start = 1'b0; abandon = 1'b0; signmul = 1'b0;
        acc_en = 1'b0; acc_sub = 1'b0; opr1 = '0; opr2 = '0; hilo_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset ready", 64'(ready), 64'd0);
        chk("reset res", res, 64'd0);
        chk("reset state", 64'(state), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors with hand-computed results.
        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].name, vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].ae, vecs[i].asb, vecs[i].h);
            chk({vecs[i].name, " table exp"}, model(vecs[i].s, vecs[i].ae, vecs[i].asb,
                vecs[i].a, vecs[i].b, vecs[i].h), vecs[i].exp);
        end

        // Abandon on the 10th MulOn edge, then restart immediately.
        signmul = 1'b0; acc_en = 1'b0; acc_sub = 1'b0;
        opr1 = 32'h1357_9BDF; opr2 = 32'h0246_8ACE; start = 1'b1;
        @(posedge clk);                 // E0
        @(negedge clk);
        repeat (9) begin
            @(posedge clk);
            @(negedge clk);
        end
        abandon = 1'b1;
        @(posedge clk);                 // E10 flushes
        @(negedge clk);
        abandon = 1'b0;
        chk("abandon ready", 64'(ready), 64'd0);
        chk("abandon res", res, 64'd0);
        chk("abandon state", 64'(state), 64'd0);
        run_op("restart", 1'b0, 32'h8000_0000, 32'd2, 1'b0, 1'b0, 64'd0);
        chk("restart const", model(1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'd2, 64'd0),
            64'h0000_0001_0000_0000);

        // Start dropped mid-iteration: no result ever appears.
        opr1 = 32'd9; opr2 = 32'd9; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        repeat (5) @(negedge clk);
        start = 1'b0;
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready) n++;
        end
        chk("dropped start ready", 64'(n), 64'd0);
        chk("dropped start state", 64'(state), 64'd0);

        // Asynchronous reset mid-MulOn, between edges.
        opr1 = 32'd1000; opr2 = 32'd3000; start = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #3;
        chk("mulon before rst", 64'(state), 64'd1);
        rst = 1'b1;
        #1;
        chk("async rst state", 64'(state), 64'd0);
        chk("async rst ready", 64'(ready), 64'd0);
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);

        // Asynchronous reset while a result is being held.
        opr1 = 32'd0; opr2 = 32'd5; start = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("held before rst", res, 64'd0);
        chk("ready before rst", 64'(ready), 64'd1);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; opr1 = 32'd6; opr2 = 32'd7;
        repeat (36) @(posedge clk);
        @(negedge clk);
        chk("held res 42", res, 64'd42);
        #1 rst = 1'b1;
        #1;
        chk("async rst held res", res, 64'd0);
        chk("async rst held ready", 64'(ready), 64'd0);
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        run_op("after rst", 1'b1, 32'hFFFF_FFF0, 32'd16, 1'b0, 1'b0, 64'd0);

        // Randomized operations against the reference model.
        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 7) == 0) ra = 32'd0;
            if ($urandom_range(0, 7) == 0) rb = 32'h8000_0000;
            run_op("random", 1'($urandom_range(0, 1)), ra, rb, 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), {$urandom, $urandom});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
